seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Time-multiplexed driver for NUM_DIGITS common-cathode seven-segment digits that share one 8-bit segment bus.
- Scans the digits at a programmable refresh rate and decodes a 5-bit value per digit: hex nibble plus decimal point.
- Adds per-digit blanking, PWM brightness, and a self-timed "chaser" animation mode.
- Sits between the processor's display register file and the board pins, replacing the single-digit static decoder.

Parameters:
- NUM_DIGITS, 4: number of scanned digits (2..8).
- DIV_W, 12: width of the refresh prescaler and of refresh_div_in.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- values_in, input, 5*NUM_DIGITS: digit k occupies [5k+4:5k]; bits [3:0] are the hex value, bit 4 is the decimal point.
- blank_mask_in, input, NUM_DIGITS: 1 = digit k is blanked.
- anim_en_in, input, 1: 1 = chaser animation replaces the decoded values.
- display_on_in, input, 1: 0 = all outputs forced to 0.
- brightness_in, input, 4: PWM duty; on-fraction = (brightness_in+1)/16.
- refresh_div_in, input, DIV_W: digit slot length = refresh_div_in+1 clocks.
- seg_out, output, 8: segment bus; bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle, bit7 dp; active-high.
- dig_sel_out, output, NUM_DIGITS: one-hot or zero, active-high digit enable.
- frame_done_out, output, 1: one-cycle pulse each time the scan wraps from the last digit to digit 0.

Behaviour:
- Reset: seg_out=0, dig_sel_out=0, frame_done_out=0. prescaler, digit index, phase counter and animation step all = 0.
- Prescaler: counts up each clk. When count >= refresh_div_in it produces a tick and returns to 0. The >= compare means a reduced refresh_div_in mid-count ticks on the next cycle. refresh_div_in=0 ticks every cycle.
- Digit index: on tick, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. On the wrapping tick, frame_done_out=1 for exactly that cycle (registered).
- PWM: a 4-bit phase counter increments every clk and wraps 15->0 (free-running). A digit is lit when phase <= brightness_in. brightness_in=15 means always lit.
- Hex decode, bits 6..0:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - bit7 = dp bit of the selected digit.
- Animation:
  - A 3-bit step counter (0..5, wraps 5->0) advances on each frame_done pulse while anim_en_in=1.
  - Digit k shows the single outer segment with bit index (step+k) mod 6; dp=0.
  - When anim_en_in=0 the step is held at 0, so re-entering animation always starts at step 0.
- Output priority, registered one cycle after idx/phase: display_on_in=0 > blank_mask_in[idx]=1 > PWM off-phase > normal.
  - display_on_in=0: seg_out=0, dig_sel_out=0.
  - blank_mask_in[idx]=1 or PWM off-phase: seg_out=0, dig_sel_out=0.
  - Normal: dig_sel_out=1<<idx, seg_out = decode or animation pattern.
- Counters keep running while display_on_in=0 or while digits are blanked. Scan timing is never disturbed.
- Inputs are sampled every cycle; a value change shows on the next registered output.
- Reset asserted mid-frame: the next cycle equals the reset state, and the scan restarts at digit 0.

Test Plan:
- Reset with NUM_DIGITS=4, refresh_div_in=3, brightness_in=15, values_in digits {3:0x12,2:0x03,1:0x0A,0:0x06} -> dig_sel_out steps 0001,0010,0100,1000 every 4 clocks. seg_out = 1111101, 1110111, 1001111 (dp=0), 11011011 (dp=1). frame_done_out pulses once per 16 clocks.
- brightness_in=3, refresh_div_in=15 -> within each 16-clock slot dig_sel_out is high for 4 of 16 cycles, phase-aligned to phase 0..3. brightness_in=0 -> 1 of 16.
- blank_mask_in=0100 -> digit 2 slot shows seg_out=0, dig_sel_out=0; digits 0, 1 and 3 are unaffected; frame_done_out period is unchanged.
- anim_en_in=1, refresh_div_in=0 -> frame 0: digits 0..3 show bits 0,1,2,3. Frame 1: bits 1,2,3,4. Frame 6 repeats frame 0. Dropping and raising anim_en_in restarts at frame 0.
- display_on_in low for 10 cycles mid-frame -> all outputs 0. After it rises, the scan index continues as if never interrupted. Reset pulse mid-slot -> all outputs 0 next cycle, then digit 0 after the slot.
- Lower refresh_div_in from 100 to 2 while the prescaler is at 50 -> tick on the next cycle, then a 3-clock slot period.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Scanned driver for NUM_DIGITS common-cathode seven-segment digits that share one segment bus.
// Latency: outputs are registered one cycle after the scan index and PWM phase they reflect.
// Backpressure: none; the scan free-runs, and inputs are sampled every cycle.
//
// A prescaler sets how long each digit slot lasts. The scan index steps through the digits.
// A free-running 4-bit phase counter gates each slot for PWM dimming.
// Display-off and blanking only gate the outputs. The scan timing is never disturbed,
// so re-enabling the display resumes exactly where the scan would have been.

module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*NUM_DIGITS-1:0] values_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask_in,
  input  logic                    anim_en_in,
  input  logic                    display_on_in,
  input  logic [3:0]              brightness_in,
  input  logic [DIV_W-1:0]        refresh_div_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel_out,
  output logic                    frame_done_out
);

  // NUM_DIGITS is limited to 2..8, so the index never needs more than 3 bits.
  localparam int IDX_W = $clog2(NUM_DIGITS);

  // Last step of the chaser. There are six outer segments: bits 0..5.
  localparam logic [2:0] STEP_LAST = 3'd5;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]      prescale_q, prescale_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [3:0]            phase_q,    phase_d;
  logic [2:0]            step_q,     step_d;
  logic                  frame_done_q, frame_done_d;
  logic [7:0]            seg_q,      seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q,  dig_sel_d;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------

  // Hex nibble to segments 6..0, in the order g f e d c b a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Chaser frame: digit k lights outer segment (step + k) mod 6.
  // The largest sum is 5 + 7 = 12, so 4 bits are enough.
  function automatic logic [7:0] chase_seg(input logic [2:0] step,
                                           input logic [IDX_W-1:0] k);
    logic [3:0] s;
    s = 4'(step) + 4'(k);
    s = s % 4'd6;
    return 8'd1 << s;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic tick;
  logic last_idx;
  logic wrap;

  // The >= compare lets a shortened refresh_div_in take effect on the next cycle.
  assign tick     = (prescale_q >= refresh_div_in);
  assign last_idx = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign wrap     = tick && last_idx;

  // Next state for the prescaler, scan index, PWM phase and chaser step.
  always_comb begin
    prescale_d   = tick ? '0 : prescale_q + 1'b1;
    idx_d        = idx_q;
    if (tick) begin
      idx_d = last_idx ? '0 : idx_q + 1'b1;
    end
    phase_d      = phase_q + 4'd1;
    frame_done_d = wrap;

    // The step advances on the same edge as the wrap.
    // Digit 0 of the new frame therefore already shows the new step.
    // Holding the step at 0 while disabled means the chaser always restarts at step 0.
    step_d = step_q;
    if (!anim_en_in) begin
      step_d = '0;
    end else if (wrap) begin
      step_d = (step_q == STEP_LAST) ? '0 : step_q + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection
  // ---------------------------------------------------------------------------
  logic [4:0] cur_val;
  logic       cur_blank;
  logic       lit;

  // Select the current digit's value and blank bit with an explicit mux.
  // This keeps non-power-of-two digit counts in range.
  always_comb begin
    cur_val   = '0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_val   = values_in[5*k +: 5];
        cur_blank = blank_mask_in[k];
      end
    end
  end

  // Gate priority: display off, then blanking, then the PWM off-phase.
  // Each of these outputs all-zero.
  assign lit = display_on_in && !cur_blank && (phase_q <= brightness_in);

  // Registered output values for this cycle's index and phase.
  always_comb begin
    seg_d     = '0;
    dig_sel_d = '0;
    if (lit) begin
      dig_sel_d = NUM_DIGITS'(1) << idx_q;
      if (anim_en_in) begin
        seg_d = chase_seg(step_q, idx_q);
      end else begin
        seg_d = {cur_val[4], hex7(cur_val[3:0])};
      end
    end
  end

  // All state updates, with a synchronous reset that restarts the scan at digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q   <= '0;
      idx_q        <= '0;
      phase_q      <= '0;
      step_q       <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= '0;
      dig_sel_q    <= '0;
    end else begin
      prescale_q   <= prescale_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      step_q       <= step_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
    end
  end

  assign seg_out        = seg_q;
  assign dig_sel_out    = dig_sel_q;
  assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan: directed scenarios followed by randomized stimulus.
// Every cycle is compared against a behavioural model kept in this bench.
// Outputs are sampled on the falling edge; inputs change only on the falling edge.

module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int DW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [5*ND-1:0]   values;
  logic [ND-1:0]     blank;
  logic              anim;
  logic              disp_on;
  logic [3:0]        bright;
  logic [DW-1:0]     div;
  logic [7:0]        seg;
  logic [ND-1:0]     dig;
  logic              fd;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(ND), .DIV_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .values_in      (values),
    .blank_mask_in  (blank),
    .anim_en_in     (anim),
    .display_on_in  (disp_on),
    .brightness_in  (bright),
    .refresh_div_in (div),
    .seg_out        (seg),
    .dig_sel_out    (dig),
    .frame_done_out (fd)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Segment table from the decode rules: segments 6..0.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Behavioural model.
  // The phase is derived from the number of clocks since reset.
  // The chaser step is the number of completed frames since animation was enabled, mod 6.
  int         m_cnt, m_idx, m_n, m_frames;
  logic [7:0] exp_seg;
  logic [ND-1:0] exp_dig;
  logic       exp_fd;

  task automatic model_edge();
    int   ph;
    int   stp;
    bit   lit;
    bit   tk;
    logic [3:0] hv;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_n = 0; m_frames = 0;
      exp_seg = '0; exp_dig = '0; exp_fd = 1'b0;
    end else begin
      ph  = m_n % 16;
      stp = m_frames % 6;
      lit = disp_on && !blank[m_idx] && (ph <= int'(bright));
      exp_seg = '0;
      exp_dig = '0;
      if (lit) begin
        exp_dig = ND'(1 << m_idx);
        if (anim) begin
          exp_seg = 8'(1 << ((stp + m_idx) % 6));
        end else begin
          hv = values[5*m_idx +: 4];
          exp_seg = {values[5*m_idx+4], hex_tab[hv]};
        end
      end
      tk     = (m_cnt >= int'(div));
      exp_fd = tk && (m_idx == ND - 1);
      if (tk) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_cnt++;
      end
      if (!anim) m_frames = 0;
      else if (exp_fd) m_frames++;
      m_n++;
    end
  endtask

  // One clock: the model consumes the same inputs the DUT sampled; compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("seg", 32'(seg), 32'(exp_seg));
    check("dig", 32'(dig), 32'(exp_dig));
    check("frame_done", 32'(fd), 32'(exp_fd));
  endtask

  initial begin
    int d0_cnt, fd_cnt, lit_cnt, d2_cnt, guard, i_sync;

    rst     = 1'b1;
    values  = {5'h12, 5'h03, 5'h0A, 5'h06};
    blank   = '0;
    anim    = 1'b0;
    disp_on = 1'b1;
    bright  = 4'd15;
    div     = 12'd3;

    // Reset state
    cycle();
    cycle();
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dig", 32'(dig), 32'h0);
    check("rst_fd",  32'(fd),  32'h0);
    rst = 1'b0;

    // Basic scan: 4-clock slots, fixed decode values, one frame pulse per 16 clocks
    d0_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (i < 16) check("scan_dig_order", 32'(dig), 32'(1 << (i / 4)));
      if (dig == 4'b0001) begin d0_cnt++; check("dec_d0", 32'(seg), 32'h7D); end
      if (dig == 4'b0010) check("dec_d1", 32'(seg), 32'h77);
      if (dig == 4'b0100) check("dec_d2", 32'(seg), 32'h4F);
      if (dig == 4'b1000) check("dec_d3", 32'(seg), 32'hDB);
      if (fd) fd_cnt++;
    end
    check("scan_d0_cycles", 32'(d0_cnt), 32'd8);
    check("scan_frames", 32'(fd_cnt), 32'd2);

    // PWM: brightness 3 gives 4/16 lit; brightness 0 gives 1/16
    bright = 4'd3; div = 12'd15;
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin cycle(); if (dig != 0) lit_cnt++; end
    check("pwm_b3_lit", 32'(lit_cnt), 32'd16);
    bright = 4'd0;
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin cycle(); if (dig != 0) lit_cnt++; end
    check("pwm_b0_lit", 32'(lit_cnt), 32'd4);

    // Blanking of digit 2; frame period unchanged
    bright = 4'd15; div = 12'd3;
    for (int i = 0; i < 16; i++) cycle();
    blank = 4'b0100;
    d0_cnt = 0; d2_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (dig == 4'b0001) d0_cnt++;
      if (dig == 4'b0100) d2_cnt++;
      if (fd) fd_cnt++;
    end
    check("blank_d2", 32'(d2_cnt), 32'd0);
    check("blank_d0", 32'(d0_cnt), 32'd8);
    check("blank_frames", 32'(fd_cnt), 32'd2);
    blank = '0;

    // Chaser from reset: frame f, digit k lights bit (f + k) mod 6
    anim = 1'b1; div = 12'd0;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 28; i++) begin
      cycle();
      check("anim_seg", 32'(seg), 32'(1 << (((i / 4) + (i % 4)) % 6)));
      check("anim_dig", 32'(dig), 32'(1 << (i % 4)));
    end
    anim = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    anim = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    anim = 1'b0;

    // Display off mid-frame: outputs dark, scan keeps running
    div = 12'd3;
    for (int i = 0; i < 6; i++) cycle();
    disp_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("off_seg", 32'(seg), 32'h0);
      check("off_dig", 32'(dig), 32'h0);
    end
    disp_on = 1'b1;
    for (int i = 0; i < 20; i++) cycle();

    // Reset pulse mid-slot
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    check("midrst_seg", 32'(seg), 32'h0);
    check("midrst_dig", 32'(dig), 32'h0);
    rst = 1'b0;
    cycle();
    check("midrst_restart", 32'(dig), 32'h1);
    for (int i = 0; i < 8; i++) cycle();

    // Lower the divider while the prescaler is at 50
    div = 12'd100;
    guard = 0;
    while (m_cnt != 50 && guard < 300) begin cycle(); guard++; end
    check("div_sync", 32'(m_cnt == 50), 32'd1);
    i_sync = m_idx;
    div = 12'd2;
    cycle();
    check("div_slot_old", 32'(dig), 32'(1 << i_sync));
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("div_slot_next", 32'(dig), 32'(1 << ((i_sync + 1) % ND)));
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("div_slot_3clk", 32'(dig), 32'(1 << ((i_sync + 2) % ND)));
    end

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      values = ($urandom_range(0, 7) == 0) ? 20'($urandom) : values;
      if ($urandom_range(0, 15) == 0) blank = ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0;
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 63) == 0) div = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 63) == 0) anim = ~anim;
      disp_on = ($urandom_range(0, 31) != 0);
      rst     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
